// File: rtl/dcf77_sync_controller.sv
// dcf77_sync_controller: qualifies DCF77 minute frames, locks after CONFIRM_FRAMES, emits sincro 2 cycles after strobe.
// No backpressure: strobes arriving mid-check are dropped. Optional counters under `DCF77_SYNC_STATS_EN.
module dcf77_sync_controller #(
  parameter int CONFIRM_FRAMES = 2,
  parameter int HOLDOVER_MIN   = 60
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        frame_strobe,
  input  logic [58:0] wb_tempbuffer,
  input  logic        tick_min,
  output logic        sincro,
  output logic [58:0] wb_frame,
  output logic        locked,
  output logic        frame_ok,
  output logic        frame_err
`ifdef DCF77_SYNC_STATS_EN
  ,
  output logic [7:0]  err_count,
  output logic [7:0]  resync_count
`endif
);

  localparam logic [2:0] CONF_TGT = 3'(CONFIRM_FRAMES);
  localparam logic [7:0] HOLD_TGT = 8'(HOLDOVER_MIN);

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    CAND   = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

  sync_state_t state, state_nxt;

  logic        checking;
  logic [58:0] chk_frame;
  logic [57:21] ref_frame;
  logic        ref_vld, ref_vld_nxt, ref_load;
  logic [2:0]  conf_cnt, conf_nxt;
  logic [7:0]  hold_cnt, hold_nxt;
  logic        sincro_nxt, ok_nxt, err_nxt;

  // BCD fields of the frame under check
  logic [3:0] min_u, hour_u, day_u, mon_u, yr_u, yr_t;
  logic [2:0] min_t;
  logic [1:0] hour_t, day_t;
  logic       mon_t;

  assign min_u  = chk_frame[24:21];
  assign min_t  = chk_frame[27:25];
  assign hour_u = chk_frame[32:29];
  assign hour_t = chk_frame[34:33];
  assign day_u  = chk_frame[39:36];
  assign day_t  = chk_frame[41:40];
  assign mon_u  = chk_frame[48:45];
  assign mon_t  = chk_frame[49];
  assign yr_u   = chk_frame[53:50];
  assign yr_t   = chk_frame[57:54];

  logic markers_ok, parity_ok, min_ok, hour_ok, day_ok, mon_ok, year_ok, frame_valid;

  assign markers_ok = !chk_frame[0] && chk_frame[20];
  assign parity_ok  = !(^chk_frame[28:21]) && !(^chk_frame[35:29]) && !(^chk_frame[58:36]);
  assign min_ok     = (min_u <= 4'd9) && (min_t <= 3'd5);
  assign hour_ok    = (hour_u <= 4'd9) &&
                      ((hour_t < 2'd2) || ((hour_t == 2'd2) && (hour_u <= 4'd3)));
  assign day_ok     = (day_u <= 4'd9) && !((day_t == 2'd0) && (day_u == 4'd0)) &&
                      ((day_t < 2'd3) || ((day_t == 2'd3) && (day_u <= 4'd1)));
  assign mon_ok     = (mon_u <= 4'd9) && (mon_t ? (mon_u <= 4'd2) : (mon_u != 4'd0));
  assign year_ok    = (yr_u <= 4'd9) && (yr_t <= 4'd9);
  assign frame_valid = markers_ok && parity_ok && min_ok && hour_ok && day_ok && mon_ok && year_ok;

  // Minute continuity: compare in binary, 59 wraps to 0 and frees the upper fields.
  logic [6:0] chk_min, ref_min, exp_min;
  logic       min_wrap, consistent;

  assign chk_min    = {4'd0, min_t} * 7'd10 + {3'd0, min_u};
  assign ref_min    = {4'd0, ref_frame[27:25]} * 7'd10 + {3'd0, ref_frame[24:21]};
  assign min_wrap   = (ref_min == 7'd59);
  assign exp_min    = min_wrap ? 7'd0 : ref_min + 7'd1;
  assign consistent = ref_vld && (chk_min == exp_min) &&
                      (min_wrap || (chk_frame[57:29] == ref_frame[57:29]));

  always_comb begin
    state_nxt   = state;
    conf_nxt    = conf_cnt;
    ref_vld_nxt = ref_vld;
    ref_load    = 1'b0;
    hold_nxt    = hold_cnt;
    sincro_nxt  = 1'b0;
    ok_nxt      = 1'b0;
    err_nxt     = 1'b0;

    if (checking) begin
      ok_nxt  = frame_valid;
      err_nxt = !frame_valid;
      if (frame_valid) begin
        ref_load    = 1'b1;
        ref_vld_nxt = 1'b1;
      end
      case (state)
        UNSYNC: begin
          if (frame_valid) begin
            conf_nxt = 3'd1;
            if (CONF_TGT == 3'd1) begin
              sincro_nxt = 1'b1;
              state_nxt  = LOCKED;
            end else begin
              state_nxt = CAND;
            end
          end
        end
        CAND: begin
          if (!frame_valid) begin
            conf_nxt    = 3'd0;
            ref_vld_nxt = 1'b0;
            state_nxt   = UNSYNC;
          end else if (consistent) begin
            conf_nxt = conf_cnt + 3'd1;
            if (conf_cnt + 3'd1 == CONF_TGT) begin
              sincro_nxt = 1'b1;
              state_nxt  = LOCKED;
            end
          end else begin
            conf_nxt = 3'd1;
          end
        end
        LOCKED: begin
          sincro_nxt = frame_valid && consistent;
        end
        default: state_nxt = UNSYNC;
      endcase
    end

    // A resync in the same cycle as a minute tick takes priority over holdover.
    if (sincro_nxt) begin
      hold_nxt = 8'd0;
    end else if ((state == LOCKED) && tick_min) begin
      if (hold_cnt + 8'd1 >= HOLD_TGT) begin
        state_nxt   = UNSYNC;
        conf_nxt    = 3'd0;
        ref_vld_nxt = 1'b0;
        hold_nxt    = 8'd0;
      end else if (hold_cnt != 8'hFF) begin
        hold_nxt = hold_cnt + 8'd1;
      end
    end

    if (state_nxt != LOCKED) begin
      hold_nxt = 8'd0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state     <= UNSYNC;
      checking  <= 1'b0;
      chk_frame <= '0;
      ref_frame <= '0;
      ref_vld   <= 1'b0;
      conf_cnt  <= 3'd0;
      hold_cnt  <= 8'd0;
      sincro    <= 1'b0;
      wb_frame  <= '0;
      locked    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      ref_vld  <= ref_vld_nxt;
      conf_cnt <= conf_nxt;
      hold_cnt <= hold_nxt;
      checking <= frame_strobe && !checking;
      if (frame_strobe && !checking) begin
        chk_frame <= wb_tempbuffer;
      end
      if (ref_load) begin
        ref_frame <= chk_frame[57:21];
      end
      if (sincro_nxt) begin
        wb_frame <= chk_frame;
      end
      sincro    <= sincro_nxt;
      locked    <= (state_nxt == LOCKED);
      frame_ok  <= ok_nxt;
      frame_err <= err_nxt;
    end
  end

`ifdef DCF77_SYNC_STATS_EN
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      err_count    <= 8'd0;
      resync_count <= 8'd0;
    end else begin
      if (err_nxt && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
      if (sincro_nxt && (state == LOCKED) && (resync_count != 8'hFF)) begin
        resync_count <= resync_count + 8'd1;
      end
    end
  end
`endif

endmodule
